// File: rtl/flash_audio_pkg.sv
// Shared types for the flash audio sequencer: FSM state encoding and sample width.
package flash_audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    FIRST,
    SECOND,
    NEXT
  } seq_state_t;

  // Pick one 16-bit sample out of a 32-bit flash word.
  function automatic logic [SAMPLE_W-1:0] word_half(input logic [2*SAMPLE_W-1:0] word,
                                                    input logic upper);
    return upper ? word[2*SAMPLE_W-1:SAMPLE_W] : word[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/flash_audio_sequencer_if.sv
// Start/finish handshake between the audio sequencer (master) and the flash word reader (slave).
interface flash_audio_sequencer_if #(
  parameter int ADDR_W = 23
);
  logic              flash_start;
  logic              flash_finish;
  logic [31:0]       flash_readdata;
  logic [ADDR_W-1:0] flash_address;

  modport master (
    output flash_start,
    output flash_address,
    input  flash_finish,
    input  flash_readdata
  );

  modport slave (
    input  flash_start,
    input  flash_address,
    output flash_finish,
    output flash_readdata
  );
endinterface

// File: rtl/flash_addr_counter.sv
// Flash word-address counter: loads the clip start for the given direction, steps +/-1 with wrap.
module flash_addr_counter #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'('h7FFFF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic              dir,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= dir ? ADDR_MAX : '0;
    end else if (step) begin
      if (dir) addr <= (addr == '0) ? ADDR_MAX : addr - ADDR_W'(1);
      else     addr <= (addr == ADDR_MAX) ? '0 : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/flash_audio_sequencer.sv
// Reads 32-bit flash words and plays them out as paced 16-bit samples (MSBs only).
// Optional FLASH_AUDIO_UNDERRUN_CNT_EN adds a saturating dropped-tick counter port.
module flash_audio_sequencer
  import flash_audio_pkg::*;
#(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'('h7FFFF),
  parameter int                OUT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
  input  logic                    play,
  input  logic                    reverse,
  input  logic                    restart,
  flash_audio_sequencer_if.master flash,
  output logic [OUT_W-1:0]        audio_data,
  output logic                    audio_valid
`ifdef FLASH_AUDIO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_count
`endif
);

  seq_state_t              state;
  logic [2*SAMPLE_W-1:0]   word_q;
  logic                    dir_q;
  logic                    restart_pend;
  logic                    start_q;
  logic                    service;
  logic                    tick_run;
  logic                    addr_step;
  logic [SAMPLE_W-1:0]     first_half;
  logic [SAMPLE_W-1:0]     second_half;
  logic [ADDR_W-1:0]       addr;
  logic                    unused_sample_bits;

  // Restart is only serviced when no read is in flight; it also swallows a coincident tick.
  assign service   = (restart | restart_pend) && (state != FETCH) && (state != LATCH);
  assign tick_run  = sample_tick & play & ~service;
  assign addr_step = (state == NEXT) & ~service;

  assign first_half         = word_half(word_q, dir_q);
  assign second_half        = word_half(word_q, ~dir_q);
  assign unused_sample_bits = ^{first_half, second_half};

  flash_addr_counter #(
    .ADDR_W   (ADDR_W),
    .ADDR_MAX (ADDR_MAX)
  ) u_addr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (service),
    .step    (addr_step),
    .dir     (reverse),
    .addr    (addr)
  );

  assign flash.flash_address = addr;
  assign flash.flash_start   = start_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      word_q       <= '0;
      dir_q        <= 1'b0;
      restart_pend <= 1'b0;
      start_q      <= 1'b0;
      audio_data   <= '0;
      audio_valid  <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      audio_valid <= 1'b0;
      if (service) begin
        restart_pend <= 1'b0;
        start_q      <= 1'b1;
        state        <= FETCH;
      end else begin
        if (restart) restart_pend <= 1'b1;
        case (state)
          IDLE: begin
            if (play) begin
              start_q <= 1'b1;
              state   <= FETCH;
            end
          end
          FETCH: begin
            // readdata is only guaranteed in the finish cycle, so the word is taken here.
            if (flash.flash_finish) begin
              word_q <= flash.flash_readdata;
              state  <= LATCH;
            end
          end
          LATCH: begin
            dir_q <= reverse;
            state <= FIRST;
          end
          FIRST: begin
            if (tick_run) begin
              audio_data  <= first_half[SAMPLE_W-1 -: OUT_W];
              audio_valid <= 1'b1;
              state       <= SECOND;
            end
          end
          SECOND: begin
            if (tick_run) begin
              audio_data  <= second_half[SAMPLE_W-1 -: OUT_W];
              audio_valid <= 1'b1;
              state       <= NEXT;
            end
          end
          NEXT: begin
            start_q <= 1'b1;
            state   <= FETCH;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FLASH_AUDIO_UNDERRUN_CNT_EN
  logic dropped;

  assign dropped = sample_tick & play & ((state == FETCH) || (state == LATCH) || (state == NEXT));

  always_ff @(posedge clk) begin
    if (!reset_n || service) begin
      underrun_count <= '0;
    end else if (dropped && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
